// File: rtl/toy_mext_wb_buf.sv
// In-order writeback buffer between the M-extension execute unit and the shared
// register-file write/commit port, with valid/ready handshakes and a flush.
module toy_mext_wb_buf #(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned REG_WIDTH      = 32,
    parameter int unsigned INST_IDX_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_vld,
    output logic                      in_rdy,
    input  logic [4:0]                in_reg_index,
    input  logic                      in_reg_wr_en,
    input  logic [REG_WIDTH-1:0]      in_reg_val,
    input  logic [INST_IDX_WIDTH-1:0] in_inst_idx,
    output logic                      wb_vld,
    input  logic                      wb_rdy,
    output logic [4:0]                wb_reg_index,
    output logic                      wb_reg_wr_en,
    output logic [REG_WIDTH-1:0]      wb_reg_val,
    output logic [INST_IDX_WIDTH-1:0] wb_inst_idx,
    output logic                      wb_commit_en,
    input  logic                      flush,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;

    logic [4:0]                rd_mem  [DEPTH];
    logic                      we_mem  [DEPTH];
    logic [REG_WIDTH-1:0]      val_mem [DEPTH];
    logic [INST_IDX_WIDTH-1:0] idx_mem [DEPTH];

    logic push, pop;

    // count never exceeds DEPTH, so its MSB alone marks the full state.
    assign in_rdy       = ~count_q[PtrW] & ~flush;
    assign wb_vld       = (count_q != '0) & ~flush;
    assign push         = in_vld & in_rdy;
    assign pop          = wb_vld & wb_rdy;
    assign wb_commit_en = pop;
    assign occupancy    = count_q;

    assign wb_reg_index = rd_mem[rd_ptr_q];
    assign wb_reg_wr_en = we_mem[rd_ptr_q] & (rd_mem[rd_ptr_q] != 5'd0);
    assign wb_reg_val   = val_mem[rd_ptr_q];
    assign wb_inst_idx  = idx_mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (PtrW+1)'(1);
                2'b01:   count_d = count_q - (PtrW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr_q]  <= in_reg_index;
            we_mem[wr_ptr_q]  <= in_reg_wr_en;
            val_mem[wr_ptr_q] <= in_reg_val;
            idx_mem[wr_ptr_q] <= in_inst_idx;
        end
    end

endmodule

// File: tb/tb_toy_mext_wb_buf.sv
// Scoreboard bench for toy_mext_wb_buf: directed scenarios followed by random traffic,
// checked every cycle against a queue-based reference model.
module tb_toy_mext_wb_buf;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned RW    = 32;
    localparam int unsigned IW    = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_vld, in_rdy, in_reg_wr_en;
    logic [4:0]    in_reg_index;
    logic [RW-1:0] in_reg_val;
    logic [IW-1:0] in_inst_idx;
    logic          wb_vld, wb_rdy, wb_reg_wr_en, wb_commit_en, flush;
    logic [4:0]    wb_reg_index;
    logic [RW-1:0] wb_reg_val;
    logic [IW-1:0] wb_inst_idx;
    logic [$clog2(DEPTH):0] occupancy;

    toy_mext_wb_buf #(.DEPTH(DEPTH), .REG_WIDTH(RW), .INST_IDX_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_reg_index(in_reg_index),
        .in_reg_wr_en(in_reg_wr_en), .in_reg_val(in_reg_val), .in_inst_idx(in_inst_idx),
        .wb_vld(wb_vld), .wb_rdy(wb_rdy), .wb_reg_index(wb_reg_index),
        .wb_reg_wr_en(wb_reg_wr_en), .wb_reg_val(wb_reg_val), .wb_inst_idx(wb_inst_idx),
        .wb_commit_en(wb_commit_en), .flush(flush), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]    rd;
        logic          we;   // already x0-qualified
        logic [RW-1:0] val;
        logic [IW-1:0] idx;
    } ent_t;

    ent_t sbq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: the buffer is a bounded queue; flush empties it, reset loses it.
    always @(negedge clk) begin : monitor
        logic ev, er;
        ent_t e, h;
        if (!rst_n) begin
            sbq.delete();
        end else begin
            ev = (sbq.size() != 0) && !flush;
            er = (sbq.size() < DEPTH) && !flush;
            check("in_rdy", 64'(in_rdy), 64'(er));
            check("wb_vld", 64'(wb_vld), 64'(ev));
            check("occupancy", 64'(occupancy), 64'(sbq.size()));
            check("wb_commit_en", 64'(wb_commit_en), 64'(ev && wb_rdy));
            if (ev) begin
                h = sbq[0];
                check("wb_reg_index", 64'(wb_reg_index), 64'(h.rd));
                check("wb_reg_wr_en", 64'(wb_reg_wr_en), 64'(h.we));
                check("wb_reg_val", 64'(wb_reg_val), 64'(h.val));
                check("wb_inst_idx", 64'(wb_inst_idx), 64'(h.idx));
            end
            if (flush) begin
                sbq.delete();
            end else begin
                if (ev && wb_rdy) void'(sbq.pop_front());
                if (in_vld && er) begin
                    e.rd  = in_reg_index;
                    e.we  = in_reg_wr_en && (in_reg_index != 5'd0);
                    e.val = in_reg_val;
                    e.idx = in_inst_idx;
                    sbq.push_back(e);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [4:0] rd, input logic we,
                       input logic [RW-1:0] val, input logic [IW-1:0] idx);
        in_vld       = v;
        in_reg_index = rd;
        in_reg_wr_en = we;
        in_reg_val   = val;
        in_inst_idx  = idx;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        wb_rdy = 1'b0;
        flush  = 1'b0;
        drv(1'b0, 5'd0, 1'b0, '0, '0);
        #3;
        check("reset in_rdy", 64'(in_rdy), 64'd1);
        check("reset wb_vld", 64'(wb_vld), 64'd0);
        check("reset occupancy", 64'(occupancy), 64'd0);
        check("reset wb_commit_en", 64'(wb_commit_en), 64'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);

        // Single result
        wb_rdy = 1'b1;
        drv(1'b1, 5'd5, 1'b1, 32'h6, 8'd3);
        cyc(1);
        drv(1'b0, 5'd0, 1'b0, '0, '0);
        cyc(3);

        // Fill, backpressure, rejected 5th push, then drain
        wb_rdy = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drv(1'b1, 5'(i), 1'b1, RW'(i), IW'(i));
            cyc(1);
        end
        drv(1'b0, 5'd0, 1'b0, '0, '0);
        wb_rdy = 1'b1;
        cyc(6);

        // Streaming with simultaneous push/pop
        for (int i = 0; i < 10; i++) begin
            drv(1'b1, 5'(i + 1), 1'b1, RW'(32'h100 + i), IW'(i));
            cyc(1);
        end
        drv(1'b0, 5'd0, 1'b0, '0, '0);
        cyc(3);

        // x0 and no-write results
        drv(1'b1, 5'd0, 1'b1, 32'hDEAD_BEEF, 8'd20);
        cyc(1);
        drv(1'b1, 5'd7, 1'b0, 32'h7777, 8'd21);
        cyc(1);
        drv(1'b0, 5'd0, 1'b0, '0, '0);
        cyc(3);

        // Flush with 3 buffered entries
        wb_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 5'd9, 1'b1, RW'(32'hA0 + i), IW'(30 + i));
            cyc(1);
        end
        drv(1'b1, 5'd9, 1'b1, 32'hEE, 8'd33);
        flush  = 1'b1;
        wb_rdy = 1'b1;
        cyc(1);
        flush = 1'b0;
        drv(1'b1, 5'd4, 1'b1, 32'h55, 8'd40);
        cyc(1);
        drv(1'b0, 5'd0, 1'b0, '0, '0);
        cyc(3);

        // Asynchronous reset with two entries buffered
        wb_rdy = 1'b0;
        drv(1'b1, 5'd2, 1'b1, 32'hB1, 8'd50);
        cyc(1);
        drv(1'b1, 5'd3, 1'b1, 32'hB2, 8'd51);
        cyc(1);
        drv(1'b0, 5'd0, 1'b0, '0, '0);
        @(negedge clk);
        #2;
        check("pre-reset occupancy", 64'(occupancy), 64'd2);
        rst_n = 1'b0;
        #1;
        check("async reset wb_vld", 64'(wb_vld), 64'd0);
        check("async reset occupancy", 64'(occupancy), 64'd0);
        cyc(2);
        rst_n  = 1'b1;
        wb_rdy = 1'b1;
        cyc(1);
        drv(1'b1, 5'd6, 1'b1, 32'h11, 8'd60);
        cyc(1);
        drv(1'b0, 5'd0, 1'b0, '0, '0);
        cyc(3);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drv(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                RW'($urandom), IW'($urandom));
            wb_rdy = ($urandom_range(0, 2) != 0);
            flush  = ($urandom_range(0, 24) == 0);
            cyc(1);
        end
        drv(1'b0, 5'd0, 1'b0, '0, '0);
        flush  = 1'b0;
        wb_rdy = 1'b1;
        cyc(DEPTH + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
